// File: rtl/serial2parallel_sync.sv
// serial2parallel_sync
// Receive-side symbol framer. Hunts for SYNC_WORD in the serial code-bit
// stream, then regroups the following bits into WIDTH-bit symbols. Every
// FRAME_SYMS symbols it expects another sync word. A flywheel holds lock
// through isolated bad sync words and gives up after MAX_MISS in a row.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_HUNT   | sliding-window search for SYNC_WORD, no lock
//   ST_LOCKED | assembling payload symbols, strobing each one out
//   ST_CHECK  | collecting the SYNC_LEN bits that should be a sync word
module serial2parallel_sync #(
  parameter int                  WIDTH      = 2,
  parameter int                  SYNC_LEN   = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'hB8,
  parameter int                  FRAME_SYMS = 16,
  parameter int                  MAX_MISS   = 3
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             serial_sig,
  input  logic             bit_valid_sig,
  output logic [WIDTH-1:0] parallel_sig,
  output logic             parallel_valid_sig,
  output logic             locked_sig,
  output logic             sync_miss_sig
);

  localparam int FW = $clog2(SYNC_LEN + 1);
  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int SW = (FRAME_SYMS > 2) ? $clog2(FRAME_SYMS) : 1;
  localparam int MW = $clog2(MAX_MISS + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(SYNC_LEN);
  localparam logic [FW-1:0] FILL_LAST  = FW'(SYNC_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SYM_LAST   = SW'(FRAME_SYMS - 1);
  localparam logic [MW-1:0] MISS_LIMIT = MW'(MAX_MISS);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Only the bits that survive the next shift are stored; the bit that
  // would fall off the top is never needed, so each register is one short
  // and the full window is formed with the incoming bit appended.
  logic [SYNC_LEN-2:0] sync_q, sync_d;
  logic [WIDTH-2:0]    sym_q, sym_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]       sym_cnt_q, sym_cnt_d;
  logic [MW-1:0]       miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0]    par_q, par_d;
  logic                pvalid_q, pvalid_d;
  logic                miss_q, miss_d;

  logic [SYNC_LEN-1:0] sync_win;
  logic [WIDTH-1:0]    sym_win;

  assign sync_win = {sync_q, serial_sig};
  assign sym_win  = {sym_q, serial_sig};

  // Next-state and output decode; nothing advances without a valid bit
  always_comb begin
    logic [FW-1:0] fill_next;
    logic [MW-1:0] miss_inc;

    state_d    = state_q;
    sync_d     = sync_q;
    sym_d      = sym_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    miss_cnt_d = miss_cnt_q;
    par_d      = par_q;
    pvalid_d   = 1'b0;
    miss_d     = 1'b0;
    fill_next  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    miss_inc   = miss_cnt_q + 1'b1;

    if (bit_valid_sig) begin
      case (state_q)
        ST_HUNT: begin
          sync_d = sync_win[SYNC_LEN-2:0];
          fill_d = fill_next;
          if ((fill_next == FILL_FULL) && (sync_win == SYNC_WORD)) begin
            state_d    = ST_LOCKED;
            bit_cnt_d  = '0;
            sym_cnt_d  = '0;
            miss_cnt_d = '0;
            sym_d      = '0;
          end
        end

        ST_LOCKED: begin
          sym_d = sym_win[WIDTH-2:0];
          if (bit_cnt_q == BIT_LAST) begin
            par_d     = sym_win;
            pvalid_d  = 1'b1;
            bit_cnt_d = '0;
            if (sym_cnt_q == SYM_LAST) begin
              sym_cnt_d = '0;
              state_d   = ST_CHECK;
              sync_d    = '0;
              fill_d    = '0;
            end else begin
              sym_cnt_d = sym_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        ST_CHECK: begin
          sync_d = sync_win[SYNC_LEN-2:0];
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_LAST) begin
            fill_d    = '0;
            sync_d    = '0;
            bit_cnt_d = '0;
            sym_cnt_d = '0;
            sym_d     = '0;
            if (sync_win == SYNC_WORD) begin
              miss_cnt_d = '0;
              state_d    = ST_LOCKED;
            end else begin
              miss_d = 1'b1;
              if (miss_inc == MISS_LIMIT) begin
                miss_cnt_d = '0;
                state_d    = ST_HUNT;
              end else begin
                miss_cnt_d = miss_inc;
                state_d    = ST_LOCKED;
              end
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
          sync_d  = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_q    <= ST_HUNT;
      sync_q     <= '0;
      sym_q      <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      sym_cnt_q  <= '0;
      miss_cnt_q <= '0;
      par_q      <= '0;
      pvalid_q   <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      sym_q      <= sym_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      par_q      <= par_d;
      pvalid_q   <= pvalid_d;
      miss_q     <= miss_d;
    end
  end

  assign parallel_sig       = par_q;
  assign parallel_valid_sig = pvalid_q;
  assign sync_miss_sig      = miss_q;
  assign locked_sig         = (state_q != ST_HUNT);

endmodule

// File: tb/tb_serial2parallel_sync.sv
// Directed bench for serial2parallel_sync: acquisition, frame continuation,
// flywheel and loss of lock, gapped input, mid-symbol reset, false match.
module tb_serial2parallel_sync;

  logic       clk_sig = 1'b0;
  logic       reset_sig;
  logic       serial_sig;
  logic       bit_valid_sig;
  logic [1:0] parallel_sig;
  logic       parallel_valid_sig;
  logic       locked_sig;
  logic       sync_miss_sig;

  int   n_checks = 0;
  int   n_errors = 0;
  logic gapped   = 1'b0;

  logic       o_pv, o_lock, o_miss;
  logic [1:0] o_par;

  always #5 clk_sig = ~clk_sig;

  serial2parallel_sync #(
    .WIDTH      (2),
    .SYNC_LEN   (8),
    .SYNC_WORD  (8'hB8),
    .FRAME_SYMS (4),
    .MAX_MISS   (2)
  ) dut (
    .clk_sig            (clk_sig),
    .reset_sig          (reset_sig),
    .serial_sig         (serial_sig),
    .bit_valid_sig      (bit_valid_sig),
    .parallel_sig       (parallel_sig),
    .parallel_valid_sig (parallel_valid_sig),
    .locked_sig         (locked_sig),
    .sync_miss_sig      (sync_miss_sig)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the falling edge, sample just after the rising edge
  task automatic step(input logic b, input logic v);
    @(negedge clk_sig);
    serial_sig    = b;
    bit_valid_sig = v;
    @(posedge clk_sig);
    #1;
    o_pv   = parallel_valid_sig;
    o_par  = parallel_sig;
    o_lock = locked_sig;
    o_miss = sync_miss_sig;
  endtask

  // One accepted bit; in gapped mode an idle cycle with junk data follows
  task automatic vbit(input logic b, input string tag);
    logic       s_pv, s_lock, s_miss;
    logic [1:0] s_par;
    step(b, 1'b1);
    if (gapped) begin
      s_pv = o_pv; s_par = o_par; s_lock = o_lock; s_miss = o_miss;
      step(1'($urandom_range(0, 1)), 1'b0);
      check({tag, " idle pv"},   32'(o_pv),   32'd0);
      check({tag, " idle par"},  32'(o_par),  32'(s_par));
      check({tag, " idle lock"}, 32'(o_lock), 32'(s_lock));
      check({tag, " idle miss"}, 32'(o_miss), 32'd0);
      o_pv = s_pv; o_par = s_par; o_lock = s_lock; o_miss = s_miss;
    end
  endtask

  task automatic do_reset(input string tag);
    reset_sig = 1'b1;
    step(1'b0, 1'b0);
    check({tag, " pv"},   32'(o_pv),   32'd0);
    check({tag, " par"},  32'(o_par),  32'd0);
    check({tag, " lock"}, 32'(o_lock), 32'd0);
    check({tag, " miss"}, 32'(o_miss), 32'd0);
    step(1'b0, 1'b0);
    reset_sig = 1'b0;
  endtask

  // Sync word found while hunting: lock rises only after the 8th bit
  task automatic hunt_byte(input logic [7:0] b, input string tag);
    for (int i = 0; i < 8; i++) begin
      vbit(b[7-i], tag);
      check({tag, " pv"},   32'(o_pv),   32'd0);
      check({tag, " lock"}, 32'(o_lock), (i == 7) ? 32'd1 : 32'd0);
    end
  endtask

  // Bits that must never lock or strobe
  task automatic quiet_byte(input logic [7:0] b, input string tag);
    for (int i = 0; i < 8; i++) begin
      vbit(b[7-i], tag);
      check({tag, " pv"},   32'(o_pv),   32'd0);
      check({tag, " lock"}, 32'(o_lock), 32'd0);
    end
  endtask

  // One frame of payload = 4 two-bit symbols
  task automatic payload_byte(input logic [7:0] b, input string tag);
    for (int i = 0; i < 8; i++) begin
      vbit(b[7-i], tag);
      check({tag, " pv"}, 32'(o_pv), 32'(i % 2));
      if (i % 2 == 1)
        check({tag, " par"}, 32'(o_par), 32'((b >> (7 - i)) & 8'd3));
      check({tag, " lock"}, 32'(o_lock), 32'd1);
      check({tag, " miss"}, 32'(o_miss), 32'd0);
    end
  endtask

  // Sync word while locked; result shows after the 8th bit
  task automatic sync_byte(input logic [7:0] b, input logic exp_miss,
                           input logic exp_lock, input string tag);
    for (int i = 0; i < 8; i++) begin
      vbit(b[7-i], tag);
      check({tag, " pv"},   32'(o_pv),   32'd0);
      check({tag, " miss"}, 32'(o_miss), (i == 7) ? 32'(exp_miss) : 32'd0);
      check({tag, " lock"}, 32'(o_lock), (i == 7) ? 32'(exp_lock) : 32'd1);
    end
  endtask

  initial begin
    logic [7:0] pre;
    reset_sig     = 1'b1;
    serial_sig    = 1'b0;
    bit_valid_sig = 1'b0;
    pre           = 8'b1010_0000;

    // Acquire
    do_reset("rst0");
    for (int i = 0; i < 3; i++) begin
      vbit(pre[7-i], "prefix");
      check("prefix lock", 32'(o_lock), 32'd0);
    end
    hunt_byte(8'hB8, "acq sync");
    payload_byte(8'h9C, "acq frame");

    // Frame continuation
    sync_byte(8'hB8, 1'b0, 1'b1, "cont sync");
    payload_byte(8'h36, "cont frame");

    // Flywheel, miss-count clear, then loss of lock
    sync_byte(8'hB9, 1'b1, 1'b1, "fly bad");
    payload_byte(8'hC5, "fly frame1");
    sync_byte(8'hB8, 1'b0, 1'b1, "fly good");
    payload_byte(8'h69, "fly frame2");
    sync_byte(8'h00, 1'b1, 1'b1, "loss bad1");
    payload_byte(8'hA3, "loss frame");
    sync_byte(8'hFF, 1'b1, 1'b0, "loss bad2");
    quiet_byte(8'h55, "lost quiet");
    hunt_byte(8'hB8, "reacq sync");
    payload_byte(8'h9C, "reacq frame");

    // Gapped input
    do_reset("rst1");
    gapped = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vbit(pre[7-i], "gap prefix");
      check("gap prefix lock", 32'(o_lock), 32'd0);
    end
    hunt_byte(8'hB8, "gap sync");
    payload_byte(8'h9C, "gap frame");
    gapped = 1'b0;

    // Reset mid-symbol
    sync_byte(8'hB8, 1'b0, 1'b1, "mid sync");
    vbit(1'b1, "mid bit");
    check("mid bit pv", 32'(o_pv), 32'd0);
    reset_sig = 1'b1;
    step(1'b0, 1'b1);
    reset_sig = 1'b0;
    check("mid rst pv",   32'(o_pv),   32'd0);
    check("mid rst par",  32'(o_par),  32'd0);
    check("mid rst lock", 32'(o_lock), 32'd0);
    check("mid rst miss", 32'(o_miss), 32'd0);
    quiet_byte(8'h9C, "mid quiet1");
    quiet_byte(8'h9C, "mid quiet2");
    hunt_byte(8'hB8, "mid resync");
    payload_byte(8'h9C, "mid frame");

    // False-match guard: 0111000 then a trailing 0
    do_reset("rst2");
    quiet_byte(8'h70, "false");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
